debounce_strobe: RTL

//  Conditions one raw, asynchronous, bouncy input (switch/button) into a clean registered level and a one-cycle change strobe.

---
 rtl/debounce_pkg.sv | 12 +
 rtl/debounce_strobe_if.sv | 29 ++
 rtl/debounce_strobe_sync_chain.sv | 24 ++
 rtl/debounce_strobe.sv | 132 +++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants for the debounce_strobe input-conditioning block.
package debounce_pkg;

  typedef logic state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_COUNT = 1'b1;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 16;

endpackage

// File: rtl/debounce_strobe_if.sv
// Raw input and conditioned outputs of debounce_strobe; master drives the raw input.
interface debounce_strobe_if;

  logic din_raw;
  logic dout;
  logic en_pulse;
  logic rise;
  logic fall;
  logic busy;

  modport master (
    output din_raw,
    input  dout,
    input  en_pulse,
    input  rise,
    input  fall,
    input  busy
  );

  modport slave (
    input  din_raw,
    output dout,
    output en_pulse,
    output rise,
    output fall,
    output busy
  );

endinterface

// File: rtl/debounce_strobe_sync_chain.sv
// N-flop synchroniser for an asynchronous single-bit input; no logic between stages.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // shift register, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ff <= {STAGES{1'b0}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/debounce_strobe.sv
// Debouncer: dout flips only after STABLE_CYCLES consecutive cycles of disagreement,
// with a registered one-cycle en_pulse/rise/fall coincident with the new level.
module debounce_strobe
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  debounce_strobe_if.slave   bus
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             flip;
  logic             dout_reg;
  logic             dout_nxt;
  logic             en_reg;
  logic             en_nxt;
  logic             rise_reg;
  logic             rise_nxt;
  logic             fall_reg;
  logic             fall_nxt;
  logic             busy_reg;
  logic             busy_nxt;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.din_raw),
    .q     (s)
  );

  // state, counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= CNT_ZERO;
      dout_reg <= 1'b0;
      en_reg   <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      busy_reg <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dout_reg <= dout_nxt;
      en_reg   <= en_nxt;
      rise_reg <= rise_nxt;
      fall_reg <= fall_nxt;
      busy_reg <= busy_nxt;
    end
  end

  // next state and counter; the counter stops at CNT_LAST, where the flip happens instead
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (s != dout_reg) begin
          state_nxt = ST_COUNT;
          cnt_nxt   = CNT_ONE;
        end else begin
          state_nxt = ST_IDLE;
          cnt_nxt   = CNT_ZERO;
        end
      end
      ST_COUNT: begin
        if (s == dout_reg) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt < CNT_LAST) begin
          state_nxt = ST_COUNT;
          cnt_nxt   = cnt + CNT_ONE;
        end else begin
          state_nxt = ST_IDLE;
          cnt_nxt   = CNT_ZERO;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    flip     = 1'b0;
    dout_nxt = dout_reg;
    en_nxt   = 1'b0;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    busy_nxt = 1'b0;
    if ((state == ST_COUNT) && (s != dout_reg) && (cnt == CNT_LAST)) begin
      flip = 1'b1;
    end else begin
      flip = 1'b0;
    end
    if (flip) begin
      dout_nxt = ~dout_reg;
      en_nxt   = 1'b1;
      rise_nxt = ~dout_reg;
      fall_nxt = dout_reg;
    end else begin
      dout_nxt = dout_reg;
      en_nxt   = 1'b0;
      rise_nxt = 1'b0;
      fall_nxt = 1'b0;
    end
    busy_nxt = (state_nxt == ST_COUNT);
  end

  assign bus.dout     = dout_reg;
  assign bus.en_pulse = en_reg;
  assign bus.rise     = rise_reg;
  assign bus.fall     = fall_reg;
  assign bus.busy     = busy_reg;

endmodule
